ahb_sram_subordinate: RTL

AHB_SRAM_SUBORDINATE -- requirements
Module: ahb_sram_subordinate

---
 rtl/ahb_sram_subordinate.sv | 134 +++++++++++++
 1 files changed

// File: rtl/ahb_sram_subordinate.sv
// rtl/ahb_sram_subordinate.sv - AHB-Lite SRAM subordinate with wait states and two-cycle ERROR response
// Each beat is checked for range, size and alignment; writes commit in the final data-phase cycle.
module ahb_sram_subordinate #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned BASE_ADDR   = 0
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic                    HSELx,
  input  logic                    HREADY,
  input  logic [ADDR_WIDTH-1:0]   HADDR,
  input  logic [1:0]              HTRANS,
  input  logic                    HWRITE,
  input  logic [2:0]              HSIZE,
  input  logic [2:0]              HBURST,
  input  logic [3:0]              HPROT,
  input  logic                    HMASTLOCK,
  input  logic [DATA_WIDTH-1:0]   HWDATA,
  input  logic [DATA_WIDTH/8-1:0] HWSTRB,
  output logic [DATA_WIDTH-1:0]   HRDATA,
  output logic                    HREADYOUT,
  output logic                    HRESP
);
  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam int unsigned BW = $clog2(NB);
  localparam int unsigned IW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [ADDR_WIDTH-1:0] BASE_A   = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] REGION_A = ADDR_WIDTH'(MEM_WORDS * NB);
  localparam logic [2:0] WS = 3'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_e;

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            dp_valid_q, dp_write_q;
  logic [IW-1:0]   dp_idx_q;
  logic [BW-1:0]   dp_lo_q;
  logic [2:0]      dp_size_q;

  logic [ADDR_WIDTH-1:0] off;
  logic [BW-1:0]         align_mask;
  logic [IW-1:0]         a_idx;
  logic                  legal, accept, take, wr_en;
  logic [NB-1:0]         lane_mask, wr_be;
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic [DATA_WIDTH-1:0] rdata_q, fwd_word;

  logic unused_inputs;
  assign unused_inputs = ^{HPROT, HMASTLOCK, HBURST, HTRANS[0]};

  // Address-phase legality; an address below BASE wraps to a huge offset and fails the range test.
  always_comb begin
    off = HADDR - BASE_A;
    for (int i = 0; i < int'(BW); i++) align_mask[i] = (i < int'(HSIZE));
    legal = (off < REGION_A) && (HSIZE <= 3'(BW)) && ((HADDR[BW-1:0] & align_mask) == '0);
    a_idx = off[BW +: IW];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (state_q)
      S_WAIT: if (cnt_q != 3'd0) begin
        HREADYOUT = 1'b0;
        cnt_d     = cnt_q - 3'd1;
      end
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_d   = S_ERR2;
      end
      S_ERR2: HRESP = 1'b1;
      default: ;
    endcase
    accept = HSELx && HREADY && HTRANS[1] && HREADYOUT;
    take   = accept && legal;
    if (HREADYOUT) begin
      state_d = S_IDLE;
      if (accept) begin
        if (!legal) state_d = S_ERR1;
        else if (WS != 3'd0) begin
          state_d = S_WAIT;
          cnt_d   = WS;
        end
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_idx_q   <= '0;
      dp_lo_q    <= '0;
      dp_size_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (HREADYOUT) begin
        dp_valid_q <= take;
        if (take) begin
          dp_write_q <= HWRITE;
          dp_idx_q   <= a_idx;
          dp_lo_q    <= HADDR[BW-1:0];
          dp_size_q  <= HSIZE;
        end
      end
    end
  end

  // A lane is enabled when it falls in the same naturally aligned 2^size block as the start byte.
  always_comb begin
    for (int b = 0; b < int'(NB); b++)
      lane_mask[b] = ((b >> dp_size_q) == (int'(dp_lo_q) >> dp_size_q));
    wr_en = dp_valid_q && dp_write_q && HREADYOUT;
    wr_be = wr_en ? (HWSTRB & lane_mask) : '0;
    for (int b = 0; b < int'(NB); b++)
      fwd_word[8*b +: 8] = (wr_be[b] && (dp_idx_q == a_idx)) ? HWDATA[8*b +: 8] : mem[a_idx][8*b +: 8];
    HRDATA = (dp_valid_q && !dp_write_q && HREADYOUT) ? rdata_q : '0;
  end

  always_ff @(posedge HCLK) begin
    for (int b = 0; b < int'(NB); b++)
      if (wr_be[b]) mem[dp_idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
    if (take && !HWRITE) rdata_q <= fwd_word;
  end
endmodule
